// File: rtl/systolic_os_array.sv
// Purpose : output-stationary ROWS x COLS multiply-accumulate grid with input skewing,
//           a K-beat accumulation run and a handshaked row-by-row result drain.
// Latency : 1 + k_len + (ROWS+COLS-1) + ROWS cycles from start to done without stalls.
// Backpressure: in_ready is a pure state decode (high in LOAD); out_data/out_row hold
//           while out_ready is low in DRAIN.
//
// Ports
//   clk        posedge clock for all logic
//   rstn       asynchronous reset, active-high (clears FSM, grid, skew and counters)
//   start      begin a run (sampled only in IDLE), k_len sampled with it
//   in_valid / in_ready / in_w / in_a   operand beat stream (weights per row lane,
//                                       activations per column lane)
//   out_valid / out_ready / out_data / out_row   result row stream, one row per handshake
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse following the last row handshake
module systolic_os_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DW     = 8,
    parameter int AW     = 32,
    parameter int KW     = 16,
    parameter int SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DW-1:0]      in_w,
    input  logic [COLS*DW-1:0]      in_a,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*AW-1:0]      out_data,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic                    busy,
    output logic                    done
);

    localparam int RW        = $clog2(ROWS);
    localparam int FLUSH_CYC = ROWS + COLS - 1;
    localparam int FW        = $clog2(FLUSH_CYC);

    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_q,  beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [RW-1:0] row_q,   row_d;
    logic          done_q,  done_d;

    // Single-cycle strobe: wipe the grid and skew pipes at the start of a run.
    logic          clear;
    // Beat is taken into the skew front this cycle.
    logic          accept;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    // Skew delay lines: entry [lane][d] holds that lane delayed d+1 cycles.
    // Lane n taps entry n-1; lane 0 is taken straight from the front.
    logic [DW-1:0] w_sk_q [ROWS][ROWS-1];
    logic [DW-1:0] w_sk_d [ROWS][ROWS-1];
    logic [DW-1:0] a_sk_q [COLS][COLS-1];
    logic [DW-1:0] a_sk_d [COLS][COLS-1];

    logic [DW-1:0] w_front [ROWS];
    logic [DW-1:0] a_front [COLS];
    logic [DW-1:0] w_lane  [ROWS];
    logic [DW-1:0] a_lane  [COLS];

    // Inter-PE pipeline: w_q[i][j] sits between columns j and j+1,
    // a_q[i][j] between rows i and i+1.
    logic [DW-1:0] w_q [ROWS][COLS-1];
    logic [DW-1:0] w_d [ROWS][COLS-1];
    logic [DW-1:0] a_q [ROWS-1][COLS];
    logic [DW-1:0] a_d [ROWS-1][COLS];

    // Operands presented to each PE this cycle.
    logic [DW-1:0] w_in [ROWS][COLS];
    logic [DW-1:0] a_in [ROWS][COLS];

    logic [AW-1:0] acc_q [ROWS][COLS];
    logic [AW-1:0] acc_d [ROWS][COLS];

    // Full-precision DW x DW product, sign- or zero-extended to the accumulator width.
    function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] w, input logic [DW-1:0] a);
        logic signed [2*DW-1:0] p_s;
        logic        [2*DW-1:0] p_u;
        p_s = (2*DW)'($signed(w)) * (2*DW)'($signed(a));
        p_u = (2*DW)'(w) * (2*DW)'(a);
        if (SIGNED != 0) begin
            mac_prod = AW'(p_s);
        end else begin
            mac_prod = AW'(p_u);
        end
    endfunction

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clear   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    k_len_d = k_len;
                    beat_d  = '0;
                    flush_d = '0;
                    row_d   = '0;
                    // A zero-length run still flushes and drains all-zero rows.
                    state_d = (k_len == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_len_q - KW'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Enough cycles for the last beat to cross the skew and reach PE(ROWS-1,COLS-1).
                if (flush_q == FLUSH_LAST) begin
                    flush_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign accept = (state_q == S_LOAD) && in_valid;

    // ------------------------------------------------------------------
    // Input skew: lane n of each operand is delayed n cycles so that the
    // diagonal wavefront meets at the right PE. Idle cycles inject zeros.
    // ------------------------------------------------------------------
    always_comb begin
        w_front = '{default: '0};
        a_front = '{default: '0};
        w_sk_d  = '{default: '0};
        a_sk_d  = '{default: '0};
        w_lane  = '{default: '0};
        a_lane  = '{default: '0};

        for (int i = 0; i < ROWS; i++) begin
            w_front[i] = accept ? in_w[i*DW +: DW] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            a_front[j] = accept ? in_a[j*DW +: DW] : '0;
        end

        if (!clear) begin
            for (int i = 0; i < ROWS; i++) begin
                w_sk_d[i][0] = w_front[i];
                for (int d = 1; d < ROWS - 1; d++) begin
                    w_sk_d[i][d] = w_sk_q[i][d-1];
                end
            end
            for (int j = 0; j < COLS; j++) begin
                a_sk_d[j][0] = a_front[j];
                for (int d = 1; d < COLS - 1; d++) begin
                    a_sk_d[j][d] = a_sk_q[j][d-1];
                end
            end
        end

        w_lane[0] = w_front[0];
        for (int i = 1; i < ROWS; i++) begin
            w_lane[i] = w_sk_q[i][i-1];
        end
        a_lane[0] = a_front[0];
        for (int j = 1; j < COLS; j++) begin
            a_lane[j] = a_sk_q[j][j-1];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            w_sk_q <= '{default: '0};
            a_sk_q <= '{default: '0};
        end else begin
            w_sk_q <= w_sk_d;
            a_sk_q <= a_sk_d;
        end
    end

    // ------------------------------------------------------------------
    // PE grid: weights flow right, activations flow down, each PE keeps
    // its own running sum. The grid advances every cycle; once the skew
    // pipes have emptied the products are zero and the sums stay put.
    // ------------------------------------------------------------------
    always_comb begin
        w_in  = '{default: '0};
        a_in  = '{default: '0};
        w_d   = '{default: '0};
        a_d   = '{default: '0};
        acc_d = '{default: '0};

        for (int i = 0; i < ROWS; i++) begin
            w_in[i][0] = w_lane[i];
            for (int j = 1; j < COLS; j++) begin
                w_in[i][j] = w_q[i][j-1];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            a_in[0][j] = a_lane[j];
            for (int i = 1; i < ROWS; i++) begin
                a_in[i][j] = a_q[i-1][j];
            end
        end

        if (!clear) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS - 1; j++) begin
                    w_d[i][j] = w_in[i][j];
                end
            end
            for (int i = 0; i < ROWS - 1; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_d[i][j] = a_in[i][j];
                end
            end
            // Modulo-2^AW accumulation: wrap is intended.
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc_d[i][j] = acc_q[i][j] + mac_prod(w_in[i][j], a_in[i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            w_q   <= '{default: '0};
            a_q   <= '{default: '0};
            acc_q <= '{default: '0};
        end else begin
            w_q   <= w_d;
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers; out_data only shows a row in DRAIN
    // so nothing partial is ever visible.
    // ------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        if (state_q == S_DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                out_data[j*AW +: AW] = acc_q[row_q][j];
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_row   = row_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_os_array.sv
// Purpose : exercises three systolic_os_array builds (signed/32, unsigned/32, signed/16)
//           side by side on shared stimulus against a matrix-product reference model.
// Timing  : inputs driven #1 after posedge; outputs sampled at the same point.
module tb_systolic_os_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int KW   = 16;
    localparam int MAXK = 16;
    localparam int NDUT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic                 start     = 1'b0;
    logic [KW-1:0]        k_len     = '0;
    logic                 in_valid  = 1'b0;
    logic [ROWS*DW-1:0]   in_w      = '0;
    logic [COLS*DW-1:0]   in_a      = '0;
    logic                 out_ready = 1'b1;

    logic                 in_rdy  [NDUT];
    logic                 out_vld [NDUT];
    logic                 busy_o  [NDUT];
    logic                 done_o  [NDUT];
    logic [1:0]           orow    [NDUT];
    logic [COLS*32-1:0]   dat_s32;
    logic [COLS*32-1:0]   dat_u32;
    logic [COLS*16-1:0]   dat_s16;

    logic [DW-1:0]        wm [ROWS][MAXK];
    logic [DW-1:0]        am [COLS][MAXK];
    logic [31:0]          exp_v [NDUT][ROWS][COLS];

    int n_chk  = 0;
    int n_fail = 0;

    systolic_os_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(32), .KW(KW), .SIGNED(1)) u_dut_s32 (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_rdy[0]), .in_w(in_w), .in_a(in_a),
        .out_valid(out_vld[0]), .out_ready(out_ready), .out_data(dat_s32), .out_row(orow[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    systolic_os_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(32), .KW(KW), .SIGNED(0)) u_dut_u32 (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_rdy[1]), .in_w(in_w), .in_a(in_a),
        .out_valid(out_vld[1]), .out_ready(out_ready), .out_data(dat_u32), .out_row(orow[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    systolic_os_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(16), .KW(KW), .SIGNED(1)) u_dut_s16 (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_rdy[2]), .in_w(in_w), .in_a(in_a),
        .out_valid(out_vld[2]), .out_ready(out_ready), .out_data(dat_s16), .out_row(orow[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_col(input int d, input int j);
        logic [31:0] v;
        case (d)
            0:       v = dat_s32[j*32 +: 32];
            1:       v = dat_u32[j*32 +: 32];
            default: v = {16'h0, dat_s16[j*16 +: 16]};
        endcase
        return v;
    endfunction

    // Sum of products over the first k beats, reduced modulo 2^aw.
    function automatic logic [31:0] model(input int i, input int j, input int k,
                                          input bit sgn, input int aw);
        longint      s = 0;
        logic [63:0] m;
        for (int t = 0; t < k; t++) begin
            if (sgn) s += longint'($signed(wm[i][t])) * longint'($signed(am[j][t]));
            else     s += longint'({56'h0, wm[i][t]}) * longint'({56'h0, am[j][t]});
        end
        m = s;
        return (aw == 16) ? {16'h0, m[15:0]} : m[31:0];
    endfunction

    task automatic fill_const(input logic [DW-1:0] v);
        for (int i = 0; i < ROWS; i++) for (int t = 0; t < MAXK; t++) wm[i][t] = v;
        for (int j = 0; j < COLS; j++) for (int t = 0; t < MAXK; t++) am[j][t] = v;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < ROWS; i++) for (int t = 0; t < MAXK; t++) wm[i][t] = (i == t) ? 8'd1 : 8'd0;
        for (int j = 0; j < COLS; j++) for (int t = 0; t < MAXK; t++) am[j][t] = 8'(4*j + t + 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < ROWS; i++) for (int t = 0; t < MAXK; t++) wm[i][t] = 8'($urandom);
        for (int j = 0; j < COLS; j++) for (int t = 0; t < MAXK; t++) am[j][t] = 8'($urandom);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_in_ready%0d", tag, d),  64'(in_rdy[d]),  64'd0);
            chk($sformatf("%s_out_valid%0d", tag, d), 64'(out_vld[d]), 64'd0);
            chk($sformatf("%s_busy%0d", tag, d),      64'(busy_o[d]),  64'd0);
            chk($sformatf("%s_done%0d", tag, d),      64'(done_o[d]),  64'd0);
            chk($sformatf("%s_out_row%0d", tag, d),   64'(orow[d]),    64'd0);
            for (int j = 0; j < COLS; j++)
                chk($sformatf("%s_data%0d_c%0d", tag, d, j), 64'(got_col(d, j)), 64'd0);
        end
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready,
    // 1 five low cycles on row 1, 2 random. midstart: pulse start during LOAD.
    task automatic run(input string name, input int k, input int vmode, input int rmode, input bit midstart);
        int edges = 0, acc_cnt = 0, rows_got = 0, el = -1, done_edge = -1, low_cnt = 0;
        bit fin = 0, rdy_exp, ov_exp, dn_exp, acc, hs, tog = 1;
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    exp_v[d][i][j] = model(i, j, k, d != 1, (d == 2) ? 16 : 32);

        start = 1'b1;
        k_len = KW'(k);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
        if (k == 0) el = 1;

        while (edges < 400 && !(fin && edges > done_edge + 2)) begin
            rdy_exp = (acc_cnt < k);
            ov_exp  = (el >= 0) && (edges >= el + 7) && (rows_got < ROWS);
            dn_exp  = fin && (edges == done_edge);
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("%s_in_ready%0d@%0d", name, d, edges),  64'(in_rdy[d]),  64'(rdy_exp));
                chk($sformatf("%s_out_valid%0d@%0d", name, d, edges), 64'(out_vld[d]), 64'(ov_exp));
                chk($sformatf("%s_busy%0d@%0d", name, d, edges),      64'(busy_o[d]),  64'(!fin));
                chk($sformatf("%s_done%0d@%0d", name, d, edges),      64'(done_o[d]),  64'(dn_exp));
                if (ov_exp) begin
                    chk($sformatf("%s_out_row%0d@%0d", name, d, edges), 64'(orow[d]), 64'(rows_got));
                    for (int j = 0; j < COLS; j++)
                        chk($sformatf("%s_data%0d_r%0d_c%0d@%0d", name, d, rows_got, j, edges),
                            64'(got_col(d, j)), 64'(exp_v[d][rows_got][j]));
                end
            end

            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom);
            endcase
            if (rdy_exp && in_valid) begin
                for (int i = 0; i < ROWS; i++) in_w[i*DW +: DW] = wm[i][acc_cnt];
                for (int j = 0; j < COLS; j++) in_a[j*DW +: DW] = am[j][acc_cnt];
            end else begin
                in_w = 32'($urandom);
                in_a = 32'($urandom);
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    if (ov_exp && rows_got == 1 && low_cnt < 5) begin
                        out_ready = 1'b0;
                        low_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'($urandom);
            endcase
            if (midstart && rdy_exp && acc_cnt == 1) begin
                start = 1'b1;
                k_len = KW'($urandom);
            end else begin
                start = 1'b0;
            end
            acc = in_valid && rdy_exp;
            hs  = ov_exp && out_ready;

            @(posedge clk); #1;
            edges++;
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == k) el = edges;
            end
            if (hs) begin
                rows_got++;
                if (rows_got == ROWS) begin
                    fin = 1'b1;
                    done_edge = edges;
                end
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("%s_finished_in_budget", name), 64'(fin), 64'd1);
        chk($sformatf("%s_rows_delivered", name), 64'(rows_got), 64'(ROWS));
        if (vmode == 0 && rmode == 0)
            chk($sformatf("%s_run_length", name), 64'(done_edge), 64'(1 + k + (ROWS + COLS - 1) + ROWS));
    endtask

    initial begin
        // Reset held for 3 cycles, then quiet idle with junk on the inputs.
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("in_reset");
        rstn = 1'b0;
        #1;
        chk_reset_state("rst_release");
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'($urandom);
            in_w = 32'($urandom);
            in_a = 32'($urandom);
            @(posedge clk); #1;
            chk_reset_state($sformatf("idle%0d", c));
        end
        in_valid = 1'b0;

        fill_identity();
        run("identity", 4, 0, 0, 1'b0);

        fill_const(8'h80);
        run("neg128_k1", 1, 0, 0, 1'b0);
        fill_const(8'hFF);
        run("ff_k1", 1, 0, 0, 1'b0);
        fill_const(8'h80);
        run("neg128_k2", 2, 0, 0, 1'b0);

        fill_identity();
        run("bubbles", 4, 1, 0, 1'b1);
        run("backpressure", 4, 0, 1, 1'b0);

        // Reset in the middle of LOAD after two accepted beats.
        fill_random();
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_w = 32'($urandom);
        in_a = 32'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rstn = 1'b1;
        #1;
        chk_reset_state("rst_midload");
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk_reset_state("rst_midload_rel");
        fill_const(8'd1);
        run("after_reset_ones", 1, 0, 0, 1'b0);

        fill_random();
        run("klen0", 0, 0, 0, 1'b0);

        fill_random();
        run("rand_nostall", 7, 0, 0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            fill_random();
            run($sformatf("rand%0d", r), $urandom_range(1, MAXK), 2, 2, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
